// File: rtl/adj_to_coo_encoder.sv
// Adjacency-matrix to COO stream encoder: snapshots an NxN matrix and scans it
// row-major, emitting each set cell as a (row, col) pair on a valid/ready stream.
module adj_to_coo_encoder #(
  parameter int NUM_OF_NODES    = 6,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(NUM_OF_NODES),
  parameter int ADDR_BW         = $clog2(COO_NUM_OF_COLS),
  parameter int CNT_BW          = $clog2(COO_NUM_OF_COLS + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [NUM_OF_NODES-1:0][NUM_OF_NODES-1:0] adj_matrix,
  output logic [COO_BW-1:0]                        coo_out [0:1],
  output logic                                     coo_valid,
  input  logic                                     coo_ready,
  output logic [ADDR_BW-1:0]                       coo_address,
  output logic [CNT_BW-1:0]                        edge_count,
  output logic                                     overflow,
  output logic                                     busy,
  output logic                                     done
);

  localparam logic [COO_BW-1:0] LAST_IDX = COO_BW'(NUM_OF_NODES - 1);
  localparam logic [CNT_BW-1:0] MAX_EDGES = CNT_BW'(COO_NUM_OF_COLS);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                                   state_q;
  logic [NUM_OF_NODES-1:0][NUM_OF_NODES-1:0] snap_q;
  logic [COO_BW-1:0]                        row_q, col_q;
  logic [COO_BW-1:0]                        row_d, col_d;
  logic [COO_BW-1:0]                        coo_row_q, coo_col_q;
  logic [ADDR_BW-1:0]                       coo_address_q;
  logic [CNT_BW-1:0]                        edge_count_q;
  logic                                     coo_valid_q, overflow_q, busy_q, done_q;
  logic                                     last_flag_q;
  logic                                     last_cell, bit_set, can_emit;

  // Row-major pointer advance and per-cell decode of the snapshot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    row_d     = row_q;
    col_d     = col_q + 1'b1;
    last_cell = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    bit_set   = snap_q[row_q][col_q];
    can_emit  = (edge_count_q < MAX_EDGES);
    if (col_q == LAST_IDX) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
  end

  // NOTE: the snapshot is plain data that is always loaded before it is read, so it
  // carries no reset; leaving it out of the reset path keeps it a simple register bank.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) snap_q <= adj_matrix;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      coo_row_q     <= '0;
      coo_col_q     <= '0;
      coo_address_q <= '0;
      coo_valid_q   <= 1'b0;
      edge_count_q  <= '0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      last_flag_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            row_q        <= '0;
            col_q        <= '0;
            edge_count_q <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          row_q <= row_d;
          col_q <= col_d;
          if (bit_set && can_emit) begin
            coo_row_q     <= row_q;
            coo_col_q     <= col_q;
            coo_address_q <= ADDR_BW'(edge_count_q);
            coo_valid_q   <= 1'b1;
            last_flag_q   <= last_cell;
            state_q       <= EMIT;
          end else begin
            // A set bit past the edge budget is dropped and flagged.
            if (bit_set) overflow_q <= 1'b1;
            if (last_cell) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        EMIT: begin
          if (coo_ready) begin
            coo_valid_q  <= 1'b0;
            edge_count_q <= edge_count_q + 1'b1;
            if (last_flag_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coo_out[0]  = coo_row_q;
  assign coo_out[1]  = coo_col_q;
  assign coo_valid   = coo_valid_q;
  assign coo_address = coo_address_q;
  assign edge_count  = edge_count_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_adj_to_coo_encoder.sv
// Directed bench for adj_to_coo_encoder: known matrices, backpressure, overflow,
// mid-run disturbance, reset abort and a COO-to-matrix round trip.
module tb_adj_to_coo_encoder;

  localparam int N    = 6;
  localparam int MAXE = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [N-1:0][N-1:0] adj_matrix;
  logic [2:0]          coo_out [0:1];
  logic                coo_valid;
  logic                coo_ready;
  logic [2:0]          coo_address;
  logic [2:0]          edge_count;
  logic                overflow;
  logic                busy;
  logic                done;

  adj_to_coo_encoder #(.NUM_OF_NODES(N), .COO_NUM_OF_COLS(MAXE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .adj_matrix  (adj_matrix),
    .coo_out     (coo_out),
    .coo_valid   (coo_valid),
    .coo_ready   (coo_ready),
    .coo_address (coo_address),
    .edge_count  (edge_count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Results of the most recent run.
  int   got_row[$], got_col[$], got_addr[$];
  int   done_cyc, busy_cnt, stall_seen, stall_bad, fin_cnt;
  logic fin_ovf;

  // Drives one run; values seen at the k-th negedge after the start edge are cycle t+k.
  task automatic run(input logic [N-1:0][N-1:0] m, input int stall_addr,
                     input int stall_n, input bit disturb);
    int stall_left;
    int sr, sc;
    got_row.delete(); got_col.delete(); got_addr.delete();
    done_cyc = -1; busy_cnt = 0; stall_seen = 0; stall_bad = 0;
    fin_cnt = -1; fin_ovf = 1'bx;
    stall_left = stall_n; sr = -1; sc = -1;
    @(negedge clk);
    adj_matrix = m; start = 1'b1; coo_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (disturb && k == 3) begin start = 1'b1; adj_matrix = ~m; end
      if (disturb && k == 4) start = 1'b0;
      if (done) begin
        done_cyc = k; fin_cnt = int'(edge_count); fin_ovf = overflow;
        break;
      end
      if (busy) busy_cnt++;
      coo_ready = 1'b1;
      if (coo_valid) begin
        if (stall_n > 0 && int'(coo_address) == stall_addr) begin
          stall_seen++;
          if (sr < 0) begin
            sr = int'(coo_out[0]); sc = int'(coo_out[1]);
          end else if (int'(coo_out[0]) != sr || int'(coo_out[1]) != sc) begin
            stall_bad++;
          end
        end
        if (stall_n > 0 && int'(coo_address) == stall_addr && stall_left > 0) begin
          coo_ready = 1'b0;
          stall_left--;
        end else begin
          got_row.push_back(int'(coo_out[0]));
          got_col.push_back(int'(coo_out[1]));
          got_addr.push_back(int'(coo_address));
        end
      end
      @(negedge clk);
    end
    start = 1'b0; coo_ready = 1'b1;
  endtask

  // Runs a matrix and checks the stream against a row-major reference scan of it.
  task automatic verify(input string tag, input logic [N-1:0][N-1:0] m,
                        input int stall_addr, input int stall_n, input bit disturb);
    int exp_r[$], exp_c[$];
    int total;
    total = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (m[r][c]) begin
          total++;
          if (exp_r.size() < MAXE) begin exp_r.push_back(r); exp_c.push_back(c); end
        end
    run(m, stall_addr, stall_n, disturb);
    check($sformatf("%s.done_cycle", tag), done_cyc, 37 + exp_r.size() + stall_n);
    check($sformatf("%s.busy_cycles", tag), busy_cnt, 36 + exp_r.size() + stall_n);
    check($sformatf("%s.edge_count", tag), fin_cnt, exp_r.size());
    check($sformatf("%s.overflow", tag), fin_ovf, (total > MAXE) ? 1 : 0);
    check($sformatf("%s.n_edges", tag), got_row.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < got_row.size(); i++) begin
      check($sformatf("%s.row%0d", tag, i), got_row[i], exp_r[i]);
      check($sformatf("%s.col%0d", tag, i), got_col[i], exp_c[i]);
      check($sformatf("%s.addr%0d", tag, i), got_addr[i], i);
    end
  endtask

  logic [N-1:0][N-1:0] m, rec;

  initial begin
    reset = 1'b1; start = 1'b0; coo_ready = 1'b1; adj_matrix = '0;
    repeat (2) @(negedge clk);
    check("rst.coo_valid", coo_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.edge_count", edge_count, 0);
    check("rst.overflow", overflow, 0);
    check("rst.coo_address", coo_address, 0);
    check("rst.coo_row", coo_out[0], 0);
    check("rst.coo_col", coo_out[1], 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty matrix: pure scan, done at t+37.
    verify("zero", '0, -1, 0, 1'b0);

    // Identity: six self-loops, done at t+43.
    m = '0;
    for (int i = 0; i < N; i++) m[i][i] = 1'b1;
    verify("ident", m, -1, 0, 1'b0);

    // Backpressure: edge 1 = (2,1) held for 4 cycles, done at t+43.
    m = '0; m[0][3] = 1'b1; m[2][1] = 1'b1; m[5][5] = 1'b1;
    verify("stall", m, 1, 3, 1'b0);
    check("stall.held_cycles", stall_seen, 4);
    check("stall.unstable", stall_bad, 0);

    // Overflow: row 0 full plus (1,0),(1,1); only row 0 is emitted.
    m = '0; m[0] = '1; m[1][0] = 1'b1; m[1][1] = 1'b1;
    verify("ovf", m, -1, 0, 1'b0);

    // Restart leaves overflow cleared.
    m = '0; m[3][2] = 1'b1;
    verify("ovf_clear", m, -1, 0, 1'b0);

    // Start re-pulsed and input matrix changed mid-run: snapshot governs.
    m = '0; m[1][4] = 1'b1; m[3][0] = 1'b1; m[4][4] = 1'b1;
    verify("disturb", m, -1, 0, 1'b1);

    // Reset while an edge is waiting in EMIT aborts at once with no done.
    @(negedge clk);
    m = '0; m[0][2] = 1'b1;
    adj_matrix = m; start = 1'b1; coo_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !coo_valid; k++) @(negedge clk);
    check("rst_emit.valid_before", coo_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_emit.valid_after", coo_valid, 0);
    check("rst_emit.busy_after", busy, 0);
    begin
      int done_seen;
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      check("rst_emit.no_done", done_seen, 0);
    end
    coo_ready = 1'b1;
    m = '0; m[2][5] = 1'b1; m[4][1] = 1'b1;
    verify("post_rst", m, -1, 0, 1'b0);

    // Round trip: rebuild the matrix from the emitted COO pairs.
    for (int t = 0; t < 4; t++) begin
      int nb;
      m = '0;
      nb = $urandom_range(0, MAXE);
      for (int b = 0; b < nb; b++) m[$urandom_range(0, N-1)][$urandom_range(0, N-1)] = 1'b1;
      run(m, -1, 0, 1'b0);
      rec = '0;
      for (int i = 0; i < got_row.size(); i++)
        if (got_row[i] < N && got_col[i] < N) rec[got_row[i]][got_col[i]] = 1'b1;
      check($sformatf("rt%0d.matrix_lo", t), rec[2:0], m[2:0]);
      check($sformatf("rt%0d.matrix_hi", t), rec[5:3], m[5:3]);
      check($sformatf("rt%0d.done_seen", t), (done_cyc > 0) ? 1 : 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adj_to_coo_encoder.md
Name: adj_to_coo_encoder

Overview:
Inverse of the combination path's coo_to_adj decode. It snapshots an NxN adjacency matrix and scans it row-major, one cell per cycle. Each set bit is emitted as a COO pair (row, col) on a valid/ready stream, which can feed the combination block's coo_in. It also produces edge indices, an edge count and an overflow flag, so graph data prepared on-chip can be replayed into the GCN pipeline.

Parameters:
NUM_OF_NODES, 6, nodes in graph; the adjacency matrix is NUM_OF_NODES x NUM_OF_NODES.
COO_NUM_OF_COLS, 6, maximum number of COO edges emitted per run.
COO_BW, $clog2(NUM_OF_NODES), bit width of a node index.
ADDR_BW, $clog2(COO_NUM_OF_COLS), bit width of the edge index.
CNT_BW, $clog2(COO_NUM_OF_COLS+1), bit width of the edge counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled only in IDLE.
adj_matrix  in  [NUM_OF_NODES-1:0][NUM_OF_NODES-1:0]  adj_matrix[r][c]=1 means edge r->c.
coo_out  out  [COO_BW-1:0] x [0:1]  coo_out[0]=row (source), coo_out[1]=col (destination).
coo_valid  out  1  coo_out and coo_address hold a valid edge.
coo_ready  in  1  consumer accepts the edge when coo_valid & coo_ready.
coo_address  out  ADDR_BW  index of the current edge (0,1,2,...).
edge_count  out  CNT_BW  edges accepted this run; holds until next start.
overflow  out  1  sticky: a set bit was found after COO_NUM_OF_COLS edges were emitted.
busy  out  1  high in SCAN and EMIT.
done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, any state): state=IDLE; row/col pointers=0; coo_out=0, coo_valid=0, coo_address=0, edge_count=0, overflow=0, busy=0, done=0. All outputs are registered.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE: start=1 captures adj_matrix into a snapshot register, clears row/col/edge_count/overflow, and goes to SCAN. Changes to adj_matrix after capture have no effect on the run.
- SCAN: examines snap[row][col] each cycle.
  - Bit=0: advance the pointer.
  - Bit=1 and edge_count<COO_NUM_OF_COLS: register coo_out={row,col}, coo_address=edge_count, coo_valid=1; advance the pointer; record last_flag = (this was cell N-1,N-1); go to EMIT.
  - Bit=1 and edge_count==COO_NUM_OF_COLS: set overflow=1, drop the edge, advance the pointer.
  - Pointer advance: col++, wrapping to 0 with row++ after col=N-1.
  - If the cell just processed was (N-1,N-1) and no edge was loaded, go to DONE.
- EMIT: coo_valid=1 holds.
  - coo_out and coo_address stay stable while coo_ready=0. No timeout.
  - On coo_valid&coo_ready: coo_valid<=0, edge_count++, then go to DONE if last_flag, else to SCAN.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start in this cycle is ignored.
- start while busy or in DONE: ignored.
- Timing: start sampled at edge t. With coo_ready tied high and E emitted edges (N=6), done is high in cycle t+37+E. Scan costs 36 cycles; each emitted edge adds one EMIT cycle.
- Edges are emitted in strict row-major order. Self-loops (r==c) are emitted like any other edge.
- Reset asserted mid-run aborts immediately, with no done pulse. The next start begins a fresh run.

Test Plan:
- All-zero matrix, start at t, coo_ready=1 -> coo_valid never asserts; busy high t+1..t+36; done pulse at t+37; edge_count=0; overflow=0.
- Identity matrix (N=6), coo_ready=1 -> edges (0,0),(1,1),...,(5,5) with coo_address 0..5; edge_count=6; overflow=0; done at t+43.
- Bits (0,3),(2,1),(5,5) set; coo_ready held low 3 cycles when edge 1 is presented -> coo_out=(2,1) and coo_address=1 stay stable for 4 cycles; done at t+43 (t+40 nominal plus 3).
- 8 set bits in row 0 and row 1 (cells (0,0)-(0,5),(1,0),(1,1)), COO_NUM_OF_COLS=6 -> only (0,0)..(0,5) emitted; overflow=1 once (1,0) is scanned; edge_count=6; done still pulses.
- Start pulsed again mid-run and adj_matrix changed after capture -> both ignored; the emitted set matches the snapshot. Reset asserted during EMIT -> coo_valid=0 immediately; no done; a new start runs cleanly.
- Round trip: random adjacency matrices with 6 or fewer edges fed through this block, then coo_to_adj -> reconstructed matrix equals the input.
